// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
//   Shared types for the 4-bit accumulator ALU command path.
//   - alu_op_t  : ALU opcode (ADD, SUB, OR, XOR)
//   - alu_cmd_t : one command as issued to the ALU, {op, operand}
//   - ALU_NOP   : identity command (ADD 0), driven whenever nothing issues
// ---------------------------------------------------------------------------
package alu_pkg;

    typedef enum logic [1:0] {
        ALU_ADD = 2'b00,
        ALU_SUB = 2'b01,
        ALU_OR  = 2'b10,
        ALU_XOR = 2'b11
    } alu_op_t;

    typedef struct packed {
        alu_op_t    op;
        logic [3:0] operand;
    } alu_cmd_t;

    localparam alu_cmd_t ALU_NOP = '{op: ALU_ADD, operand: 4'h0};

endpackage

// File: rtl/alu_cmd_queue_sync_edge.sv
// ---------------------------------------------------------------------------
// sync_edge
//   Brings an asynchronous strobe pin into the clock domain and turns each
//   rising edge into a single-cycle pulse.
// Ports
//   clock     in  1  clock, all state on posedge
//   reset_L   in  1  asynchronous active-low reset
//   async_in  in  1  asynchronous input pin
//   pulse     out 1  one-cycle pulse per rising edge of async_in
// ---------------------------------------------------------------------------
module sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clock,
    input  logic reset_L,
    input  logic async_in,
    output logic pulse
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic                   sync_out_q;
    logic                   sync_out_d;

    // Shift chain; the extra flop after the chain remembers the previous
    // synchronized level for edge detection.
    always_comb begin
        sync_d     = {sync_q[SYNC_STAGES-2:0], async_in};
        sync_out_d = sync_q[SYNC_STAGES-1];
    end

    // All flops clear to 0, so a pin held high through reset is seen as a
    // fresh rising edge after release.
    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            sync_q     <= '0;
            sync_out_q <= 1'b0;
        end else begin
            sync_q     <= sync_d;
            sync_out_q <= sync_out_d;
        end
    end

    assign pulse = sync_q[SYNC_STAGES-1] & ~sync_out_q;

endmodule

// File: rtl/alu_cmd_queue.sv
// ---------------------------------------------------------------------------
// alu_cmd_queue
//   Upstream command stage for the 4-bit accumulator ALU. Commands arrive on
//   slow external pins qualified by a strobe edge, are buffered in a FIFO,
//   and are issued at most one per clock. Idle cycles drive ADD 0 (NOP).
// Ports
//   clock        in  1        clock, all state on posedge
//   reset_L      in  1        asynchronous active-low reset
//   cmd_strobe   in  1        async pin, rising edge requests one push
//   cmd_op       in  2        command opcode
//   cmd_operand  in  4        command operand
//   run          in  1        1: issue from queue, 0: hold queue and drive NOP
//   flush        in  1        synchronous clear of queue and overflow
//   op           out 2        ALU opcode, registered
//   operand      out 4        ALU operand, registered
//   issued       out 1        op/operand carry a real popped command
//   count        out CNT_W    current occupancy
//   full         out 1        count == DEPTH
//   empty        out 1        count == 0
//   overflow     out 1        sticky, a push was dropped
// ---------------------------------------------------------------------------
module alu_cmd_queue
    import alu_pkg::*;
#(
    parameter int DEPTH       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                   clock,
    input  logic                   reset_L,
    input  logic                   cmd_strobe,
    input  logic [1:0]             cmd_op,
    input  logic [3:0]             cmd_operand,
    input  logic                   run,
    input  logic                   flush,
    output logic [1:0]             op,
    output logic [3:0]             operand,
    output logic                   issued,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty,
    output logic                   overflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic             push_req;
    logic             pop;
    logic             push_ok;
    logic             push_drop;
    alu_cmd_t         cmd_in;

    alu_cmd_t         mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             overflow_q, overflow_d;
    alu_cmd_t         out_q, out_d;
    logic             issued_q, issued_d;

    sync_edge #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync_edge (
        .clock    (clock),
        .reset_L  (reset_L),
        .async_in (cmd_strobe),
        .pulse    (push_req)
    );

    assign cmd_in = '{op: alu_op_t'(cmd_op), operand: cmd_operand};

    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);

    // Next-state for pointers, occupancy, overflow and the issue register.
    // Flush wins over everything; a push into a full queue is still taken
    // when a pop frees a slot on the same edge.
    always_comb begin
        pop        = run & ~empty & ~flush;
        push_ok    = push_req & ~flush & (~full | pop);
        push_drop  = push_req & ~flush & full & ~pop;

        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        out_d      = ALU_NOP;
        issued_d   = 1'b0;

        if (flush) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            overflow_d = 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
                out_d    = mem_q[rd_ptr_q];
                issued_d = 1'b1;
            end
            if (push_ok && !pop) begin
                count_d = count_q + CNT_W'(1);
            end else if (pop && !push_ok) begin
                count_d = count_q - CNT_W'(1);
            end
            if (push_drop) begin
                overflow_d = 1'b1;
            end
        end
    end

    // Storage holds no reset; count and pointers define which slots are valid.
    always_ff @(posedge clock) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= cmd_in;
        end
    end

    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            out_q      <= ALU_NOP;
            issued_q   <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            out_q      <= out_d;
            issued_q   <= issued_d;
        end
    end

    assign op       = out_q.op;
    assign operand  = out_q.operand;
    assign issued   = issued_q;
    assign count    = count_q;
    assign overflow = overflow_q;

endmodule
